logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit for the ALU logic part.

---
 rtl/logic_unit_pipe.sv | 120 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit (AND/OR/XOR/NOR, immediate forms, LUI) with a
// 2-entry output FIFO. Optional completed-op counter: define LOGIC_PERF_CNT_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illop,
  output logic [31:0]      op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illop;
  } entry_t;

  // Immediates are always zero-extended; illegal opcodes yield 0 with illop set.
  function automatic entry_t compute(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic [IMM_W-1:0] imm);
    entry_t           e;
    logic [WIDTH-1:0] zimm;
    zimm     = WIDTH'(imm);
    e.result = '0;
    e.illop  = 1'b0;
    case (op)
      4'd0:    e.result = a & b;
      4'd1:    e.result = a | b;
      4'd2:    e.result = a ^ b;
      4'd3:    e.result = ~(a | b);
      4'd4:    e.result = a & zimm;
      4'd5:    e.result = a | zimm;
      4'd6:    e.result = a ^ zimm;
      4'd7:    e.result = zimm << (WIDTH - IMM_W);
      default: begin
        e.result = '0;
        e.illop  = 1'b1;
      end
    endcase
    e.zero  = (e.result == '0);
    return e;
  endfunction

  entry_t     mem_r [2];
  entry_t     head_s;
  logic [1:0] count_r;
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic       push_s;
  logic       pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_r[i] <= '0;
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= compute(in_op, in_a, in_b, in_imm);
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry, masked to zero while empty.
  always_comb begin
    head_s = '0;
    if (count_r != 2'd0) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign out_result = head_s.result;
  assign out_zero   = head_s.zero;
  assign out_illop  = head_s.illop;

`ifdef LOGIC_PERF_CNT_EN
  logic [31:0] op_count_r;

  // Completed-op counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= 32'd0;
    end else if (pop_s) begin
      op_count_r <= op_count_r + 32'd1;
    end
  end

  assign op_count = op_count_r;
`else
  assign op_count = 32'd0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe plus backpressure, streaming
// and mid-stall reset sequences.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illop;
  logic [31:0] op_count;

  int checks = 0;
  int errors = 0;

  logic_unit_pipe #(.WIDTH(32), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illop(out_illop), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_imm   = imm;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] sa, sb;

    vecs[0]  = '{4'd1,  32'h0000_F0F0, 32'h0F0F_0000, 16'h0000, 32'h0F0F_F0F0, 1'b0, 1'b0};
    vecs[1]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0000, 16'h8001, 32'h0000_8001, 1'b0, 1'b0};
    vecs[2]  = '{4'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'h1234, 32'h1234_0000, 1'b0, 1'b0};
    vecs[3]  = '{4'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4]  = '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0000, 32'hF000_F000, 1'b0, 1'b0};
    vecs[5]  = '{4'd2,  32'hAAAA_5555, 32'hFFFF_0000, 16'h0000, 32'h5555_5555, 1'b0, 1'b0};
    vecs[6]  = '{4'd6,  32'h1234_5678, 32'h0000_0000, 16'hFFFF, 32'h1234_A987, 1'b0, 1'b0};
    vecs[7]  = '{4'd5,  32'h0000_0000, 32'hFFFF_FFFF, 16'h8000, 32'h0000_8000, 1'b0, 1'b0};
    vecs[8]  = '{4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 32'h0000_0000, 1'b1, 1'b1};
    vecs[9]  = '{4'd0,  32'h0000_0001, 32'h0000_0003, 16'h0000, 32'h0000_0001, 1'b0, 1'b0};
    vecs[10] = '{4'd15, 32'h0000_0000, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{4'd3,  32'h0000_0000, 32'h0000_0000, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[12] = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0000, 16'h0000, 32'h0000_0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset out_zero", 32'(out_zero), 32'd0);
    chk("reset out_illop", 32'(out_illop), 32'd0);
    chk("reset op_count", op_count, 32'd0);

    // Table: one op per cycle, out_ready high, result visible right after accept.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm);
      step();
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d zero", i), 32'(out_zero), 32'(vecs[i].zero));
      chk($sformatf("vec%0d illop", i), 32'(out_illop), 32'(vecs[i].ill));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0);
    step();
    chk("drain out_valid", 32'(out_valid), 32'd0);
    chk("drain out_result", out_result, 32'd0);

    // Backpressure: two accepts fill the FIFO, third request is held.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 4'd2, 32'd1, 32'd3, 16'd0);
    step();
    chk("bp1 in_ready", 32'(in_ready), 32'd1);
    chk("bp1 head", out_result, 32'h2);
    @(negedge clk);
    drive(1'b1, 4'd2, 32'd2, 32'd7, 16'd0);
    step();
    chk("bp2 in_ready", 32'(in_ready), 32'd0);
    chk("bp2 head stable", out_result, 32'h2);
    @(negedge clk);
    drive(1'b1, 4'd2, 32'h0000_00F0, 32'h0000_000F, 16'd0);
    step();
    chk("bp3 held in_ready", 32'(in_ready), 32'd0);
    chk("bp3 head stable", out_result, 32'h2);
    chk("bp3 valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    step();
    chk("bp pop1 head", out_result, 32'h5);
    chk("bp pop1 in_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp pop2 head", out_result, 32'h0000_00FF);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0);
    step();
    chk("bp empty", 32'(out_valid), 32'd0);

    // Streaming: 100 back-to-back ANDs.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      sa = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0F0F;
      sb = ~(32'(i) * 32'h0003_0007);
      drive(1'b1, 4'd0, sa, sb, 16'(i));
      step();
      chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("stream%0d result", i), out_result, sa & sb);
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0);
    step();

    // Reset mid-stall with FIFO full.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 32'h1111_0000, 32'h0000_2222, 16'd0);
    step();
    step();
    chk("rst full in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async out_valid", 32'(out_valid), 32'd0);
    chk("rst async out_result", out_result, 32'd0);
    chk("rst async in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst rel op_count", op_count, 32'd0);
    step();
    chk("rst rel no stale", 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd5, 32'(i) << 8, 32'd0, 16'h0001);
      step();
      chk($sformatf("post rst%0d result", i), out_result, (32'(i) << 8) | 32'h1);
      @(negedge clk);
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0);
    step();
    chk("post rst drained", 32'(out_valid), 32'd0);
`ifdef LOGIC_PERF_CNT_EN
    chk("op_count after 3", op_count, 32'd3);
`else
    chk("op_count tied 0", op_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
